// File: rtl/result_collector_if.sv
// Scanner-result input and 64-bit output stream of the result collector.
// The master side drives the scanner beats and the downstream tready.
interface result_collector_if;
  logic         scn_dvld_clt;
  logic [7:0]   scn_cmd_clt;
  logic [31:0]  scn_id_clt;
  logic [255:0] scn_data_clt;
  logic [31:0]  scn_bvld_clt;
  logic         scn_end_clt;
  logic         clt_rdy_scn;
  logic [63:0]  clt_tdata;
  logic         clt_tvalid;
  logic         clt_tlast;
  logic         clt_tready;

  modport master (
    output scn_dvld_clt, scn_cmd_clt, scn_id_clt, scn_data_clt, scn_bvld_clt, scn_end_clt,
    output clt_tready,
    input  clt_rdy_scn, clt_tdata, clt_tvalid, clt_tlast
  );

  modport slave (
    input  scn_dvld_clt, scn_cmd_clt, scn_id_clt, scn_data_clt, scn_bvld_clt, scn_end_clt,
    input  clt_tready,
    output clt_rdy_scn, clt_tdata, clt_tvalid, clt_tlast
  );
endinterface

// File: rtl/result_collector.sv
// Queues scan-result beats as records in a small FIFO and serialises each one
// as a header word plus one word per SID, while keeping saturating statistics.
module result_collector #(
  parameter int DEPTH        = 4,
  parameter bit REPORT_CLEAN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ctrl_en_clt,
  result_collector_if.slave   bus,
  output logic [31:0]         clt_scan_cnt,
  output logic [31:0]         clt_virus_cnt,
  output logic [31:0]         clt_err_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      id;
    logic [7:0]       cmd;
    logic [1:0]       nsig;
    logic [2:0][31:0] sid;
    logic [2:0][31:0] off;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_SIG = 2'd2} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    else return v;
  endfunction

  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  state_t        r_state, w_state_nxt;
  logic [1:0]    r_widx, w_widx_nxt;
  logic          r_tvalid, r_tlast;
  logic [63:0]   r_tdata;
  logic          w_tvalid_nxt, w_tlast_nxt;
  logic [63:0]   w_tdata_nxt;

  rec_t  w_rec, w_head;
  logic  w_full, w_empty, w_accept, w_err, w_infected, w_push, w_pop, w_hs;
  logic  w_unused;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_accept   = bus.scn_dvld_clt & bus.clt_rdy_scn;
  assign w_err      = (bus.scn_data_clt[31:0] > 32'd3);
  assign w_infected = (bus.scn_data_clt[31:0] != 32'd0);
  assign w_push     = w_accept & (REPORT_CLEAN | w_infected);
  assign w_head     = r_mem[r_rptr];
  assign w_hs       = r_tvalid & bus.clt_tready;
  assign w_unused   = ^{bus.scn_bvld_clt, bus.scn_end_clt, bus.scn_data_clt[255:224]};

  assign bus.clt_rdy_scn = ctrl_en_clt & ~w_full & ~reset;
  assign bus.clt_tdata   = r_tdata;
  assign bus.clt_tvalid  = r_tvalid;
  assign bus.clt_tlast   = r_tlast;

  // Unpack the incoming beat into a record, clamping nsig to the three slots carried.
  always_comb begin
    w_rec      = '0;
    w_rec.id   = bus.scn_id_clt;
    w_rec.cmd  = bus.scn_cmd_clt;
    w_rec.nsig = w_err ? 2'd3 : bus.scn_data_clt[1:0];
    for (int k = 0; k < 3; k++) begin
      w_rec.sid[k] = bus.scn_data_clt[64*k+32 +: 32];
      w_rec.off[k] = bus.scn_data_clt[64*k+64 +: 32];
    end
  end

  // Record storage; only written on a push, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  // FIFO pointers and occupancy; a push is never attempted while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      clt_scan_cnt  <= 32'd0;
      clt_virus_cnt <= 32'd0;
      clt_err_cnt   <= 32'd0;
    end else begin
      clt_scan_cnt  <= sat_inc(clt_scan_cnt,  w_accept);
      clt_virus_cnt <= sat_inc(clt_virus_cnt, w_accept & w_infected);
      clt_err_cnt   <= sat_inc(clt_err_cnt,   w_accept & w_err);
    end
  end

  // Serialiser state register with registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_widx   <= 2'd0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= 64'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_widx   <= w_widx_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_tdata  <= w_tdata_nxt;
    end
  end

  // Next state, pop and next output word; the word only changes after a handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_widx_nxt   = r_widx;
    w_pop        = 1'b0;
    w_tvalid_nxt = 1'b0;
    w_tlast_nxt  = 1'b0;
    w_tdata_nxt  = 64'd0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_HDR;
        else          w_state_nxt = S_IDLE;
      end
      S_HDR: begin
        if (w_hs && (w_head.nsig == 2'd0)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          w_widx_nxt  = 2'd0;
          w_state_nxt = S_SIG;
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_SIG: begin
        if (w_hs && (r_widx == w_head.nsig - 2'd1)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          w_widx_nxt  = r_widx + 2'd1;
        end else begin
          w_state_nxt = S_SIG;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_HDR: begin
        w_tvalid_nxt = 1'b1;
        w_tdata_nxt  = {w_head.id, w_head.cmd, 21'd0, 1'b0, w_head.nsig};
        w_tlast_nxt  = (w_head.nsig == 2'd0);
      end
      S_SIG: begin
        w_tvalid_nxt = 1'b1;
        w_tdata_nxt  = {w_head.sid[w_widx_nxt], w_head.off[w_widx_nxt]};
        w_tlast_nxt  = (w_widx_nxt == w_head.nsig - 2'd1);
      end
      default: begin
        w_tvalid_nxt = 1'b0;
        w_tdata_nxt  = 64'd0;
        w_tlast_nxt  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: one task per scenario with inline checks.
module tb_result_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ctrl_en_clt = 1'b1;
  logic [31:0] scan_cnt, virus_cnt, err_cnt;
  logic [31:0] scan_cnt2, virus_cnt2, err_cnt2;
  int errors = 0;
  int checks = 0;

  result_collector_if bus ();
  result_collector_if bus2 ();

  result_collector #(.DEPTH(4), .REPORT_CLEAN(1'b1)) dut (
    .clk(clk), .reset(reset), .ctrl_en_clt(ctrl_en_clt), .bus(bus),
    .clt_scan_cnt(scan_cnt), .clt_virus_cnt(virus_cnt), .clt_err_cnt(err_cnt));

  result_collector #(.DEPTH(4), .REPORT_CLEAN(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .ctrl_en_clt(ctrl_en_clt), .bus(bus2),
    .clt_scan_cnt(scan_cnt2), .clt_virus_cnt(virus_cnt2), .clt_err_cnt(err_cnt2));

  always #5 clk = ~clk;

  // Present one beat to the main DUT for exactly one clock edge.
  task automatic send(input logic [31:0] id, input logic [7:0] cmd, input logic [31:0] nsig,
                      input logic [31:0] s0, o0, s1, o1, s2, o2);
    bus.scn_id_clt   = id;
    bus.scn_cmd_clt  = cmd;
    bus.scn_data_clt = {32'd0, o2, s2, o1, s1, o0, s0, nsig};
    bus.scn_dvld_clt = 1'b1;
    bus.scn_end_clt  = 1'b1;
    @(posedge clk); #1;
    bus.scn_dvld_clt = 1'b0;
    bus.scn_end_clt  = 1'b0;
  endtask

  // Wait (bounded) for one valid word and take it with a single-cycle tready.
  task automatic get_word(output logic [63:0] d, output logic l, output bit ok);
    ok = 1'b0; d = 64'd0; l = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.clt_tvalid === 1'b1) begin
        d = bus.clt_tdata; l = bus.clt_tlast; ok = 1'b1;
        bus.clt_tready = 1'b1;
      end
      @(posedge clk); #1;
      bus.clt_tready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.clt_rdy_scn !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", bus.clt_rdy_scn); end
    checks++; if ({bus.clt_tvalid, bus.clt_tlast, bus.clt_tdata} !== 66'd0) begin errors++; $display("FAIL reset_out: got %b %b %h want 0", bus.clt_tvalid, bus.clt_tlast, bus.clt_tdata); end
    checks++; if ({scan_cnt, virus_cnt, err_cnt} !== 96'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {scan_cnt, virus_cnt, err_cnt}); end
    reset = 1'b0;
    #1;
    checks++; if (bus.clt_rdy_scn !== 1'b1) begin errors++; $display("FAIL rdy_after_reset: got %b want 1", bus.clt_rdy_scn); end
    ctrl_en_clt = 1'b0; #1;
    checks++; if (bus.clt_rdy_scn !== 1'b0) begin errors++; $display("FAIL rdy_disabled: got %b want 0", bus.clt_rdy_scn); end
    ctrl_en_clt = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    logic [63:0] d; logic l; bit ok;
    send(32'h11, 8'h02, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (bus.clt_tvalid !== 1'b0) begin errors++; $display("FAIL clean_lat_n1: got %b want 0", bus.clt_tvalid); end
    @(posedge clk); #1;
    checks++; if (bus.clt_tvalid !== 1'b1) begin errors++; $display("FAIL clean_lat_n2: got %b want 1", bus.clt_tvalid); end
    get_word(d, l, ok);
    checks++; if (!ok || d !== 64'h00000011_02000000 || l !== 1'b1) begin errors++; $display("FAIL clean_word: got ok=%0d %h last=%b want 0000001102000000 last=1", ok, d, l); end
    checks++; if (bus.clt_tvalid !== 1'b0) begin errors++; $display("FAIL clean_after: tvalid got %b want 0", bus.clt_tvalid); end
    checks++; if (scan_cnt !== 32'd1 || virus_cnt !== 32'd0 || err_cnt !== 32'd0) begin errors++; $display("FAIL clean_cnt: got %0d %0d %0d want 1 0 0", scan_cnt, virus_cnt, err_cnt); end
  endtask

  task automatic test_infected();
    logic [63:0] d; logic l; bit ok;
    logic [63:0] exp_w [3] = '{64'h00000022_05000002, 64'h0000000A_00000040, 64'h0000000B_00000080};
    send(32'h22, 8'h05, 32'd2, 32'hA, 32'h40, 32'hB, 32'h80, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      get_word(d, l, ok);
      checks++; if (!ok || d !== exp_w[i] || l !== (i == 2)) begin errors++; $display("FAIL infected_w%0d: got ok=%0d %h last=%b want %h last=%b", i, ok, d, l, exp_w[i], (i == 2)); end
    end
    checks++; if (scan_cnt !== 32'd2 || virus_cnt !== 32'd1) begin errors++; $display("FAIL infected_cnt: got %0d %0d want 2 1", scan_cnt, virus_cnt); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic l; bit ok;
    int stable_bad = 0;
    send(32'h33, 8'h01, 32'd1, 32'hC, 32'hD0, 32'd0, 32'd0, 32'd0, 32'd0);
    get_word(d, l, ok);
    checks++; if (!ok || d !== 64'h00000033_01000001 || l !== 1'b0) begin errors++; $display("FAIL bp_hdr: got ok=%0d %h last=%b want 0000003301000001 last=0", ok, d, l); end
    for (int i = 0; i < 5; i++) begin
      if (bus.clt_tvalid !== 1'b1 || bus.clt_tdata !== 64'h0000000C_000000D0 || bus.clt_tlast !== 1'b1) stable_bad++;
      @(posedge clk); #1;
    end
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", stable_bad); end
    get_word(d, l, ok);
    checks++; if (!ok || d !== 64'h0000000C_000000D0 || l !== 1'b1) begin errors++; $display("FAIL bp_word: got ok=%0d %h last=%b want 0000000C000000D0 last=1", ok, d, l); end
    bus.clt_tready = 1'b1;
    stable_bad = 0;
    repeat (4) begin
      if (bus.clt_tvalid !== 1'b0) stable_bad++;
      @(posedge clk); #1;
    end
    bus.clt_tready = 1'b0;
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL bp_dup: got %0d extra valid cycles want 0", stable_bad); end
  endtask

  task automatic test_full();
    logic [63:0] d; logic l; bit ok;
    int rdy_bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.clt_rdy_scn !== 1'b1) rdy_bad++;
      send(32'h40 + i, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL full_rdy_early: got %0d not-ready cycles want 0", rdy_bad); end
    checks++; if (bus.clt_rdy_scn !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b want 0", bus.clt_rdy_scn); end
    send(32'h99, 8'h00, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (scan_cnt !== 32'd7 || virus_cnt !== 32'd2) begin errors++; $display("FAIL full_blocked: got %0d %0d want 7 2", scan_cnt, virus_cnt); end
    for (int i = 0; i < 4; i++) begin
      get_word(d, l, ok);
      checks++; if (!ok || d !== {32'h40 + i, 32'h0} || l !== 1'b1) begin errors++; $display("FAIL full_order%0d: got ok=%0d %h last=%b want %h last=1", i, ok, d, l, {32'h40 + i, 32'h0}); end
      if (i == 0) begin
        checks++; if (bus.clt_rdy_scn !== 1'b1) begin errors++; $display("FAIL full_rdy_back: got %b want 1", bus.clt_rdy_scn); end
      end
    end
  endtask

  task automatic test_err();
    logic [63:0] d; logic l; bit ok;
    logic [63:0] exp_w [4] = '{64'h00000055_07000003, 64'h00000001_00000010,
                               64'h00000002_00000020, 64'h00000003_00000030};
    send(32'h55, 8'h07, 32'd5, 32'h1, 32'h10, 32'h2, 32'h20, 32'h3, 32'h30);
    for (int i = 0; i < 4; i++) begin
      get_word(d, l, ok);
      checks++; if (!ok || d !== exp_w[i] || l !== (i == 3)) begin errors++; $display("FAIL err_w%0d: got ok=%0d %h last=%b want %h last=%b", i, ok, d, l, exp_w[i], (i == 3)); end
    end
    checks++; if (err_cnt !== 32'd1 || virus_cnt !== 32'd3 || scan_cnt !== 32'd8) begin errors++; $display("FAIL err_cnt: got %0d %0d %0d want 1 3 8", err_cnt, virus_cnt, scan_cnt); end
  endtask

  task automatic test_no_clean();
    int seen = 0;
    bus2.scn_id_clt   = 32'h77;
    bus2.scn_cmd_clt  = 8'h03;
    bus2.scn_data_clt = 256'd0;
    bus2.scn_dvld_clt = 1'b1;
    @(posedge clk); #1;
    bus2.scn_dvld_clt = 1'b0;
    repeat (6) begin
      if (bus2.clt_tvalid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL noclean_out: got %0d valid cycles want 0", seen); end
    checks++; if (scan_cnt2 !== 32'd1 || virus_cnt2 !== 32'd0) begin errors++; $display("FAIL noclean_cnt: got %0d %0d want 1 0", scan_cnt2, virus_cnt2); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic l; bit ok;
    int seen = 0;
    send(32'h66, 8'h09, 32'd2, 32'hE, 32'h1, 32'hF, 32'h2, 32'd0, 32'd0);
    get_word(d, l, ok);
    get_word(d, l, ok);
    checks++; if (!ok || d !== 64'h0000000E_00000001 || l !== 1'b0) begin errors++; $display("FAIL mid_w0: got ok=%0d %h last=%b want 0000000E00000001 last=0", ok, d, l); end
    checks++; if (bus.clt_tvalid !== 1'b1 || bus.clt_tdata !== 64'h0000000F_00000002) begin errors++; $display("FAIL mid_w1: got %b %h want 1 0000000F00000002", bus.clt_tvalid, bus.clt_tdata); end
    reset = 1'b1; #1;
    checks++; if (bus.clt_rdy_scn !== 1'b0) begin errors++; $display("FAIL mid_rdy: got %b want 0", bus.clt_rdy_scn); end
    @(posedge clk); #1;
    checks++; if (bus.clt_tvalid !== 1'b0 || {scan_cnt, virus_cnt, err_cnt} !== 96'd0) begin errors++; $display("FAIL mid_reset: tvalid=%b cnt=%h want 0 0", bus.clt_tvalid, {scan_cnt, virus_cnt, err_cnt}); end
    reset = 1'b0;
    bus.clt_tready = 1'b1;
    repeat (5) begin
      if (bus.clt_tvalid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    bus.clt_tready = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_tail: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    bus.scn_dvld_clt = 1'b0; bus.scn_cmd_clt = 8'd0; bus.scn_id_clt = 32'd0;
    bus.scn_data_clt = 256'd0; bus.scn_bvld_clt = 32'hFFFF_FFFF; bus.scn_end_clt = 1'b0;
    bus.clt_tready = 1'b0;
    bus2.scn_dvld_clt = 1'b0; bus2.scn_cmd_clt = 8'd0; bus2.scn_id_clt = 32'd0;
    bus2.scn_data_clt = 256'd0; bus2.scn_bvld_clt = 32'hFFFF_FFFF; bus2.scn_end_clt = 1'b0;
    bus2.clt_tready = 1'b1;
    test_reset();
    test_clean();
    test_infected();
    test_backpressure();
    test_full();
    test_err();
    test_no_clean();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
